// File: rtl/stdp_learner.sv
// rtl/stdp_learner.sv - pair-based STDP weight learner with a per-gamma-cycle update sweep
// Optional feature macro: STDP_STOCHASTIC_EN (LFSR-gated probabilistic updates).
`ifndef TIME_PERIOD
`define TIME_PERIOD 8
`endif

module stdp_learner #(
  parameter int NEURONS     = 2,
  parameter int SYNAPSES    = 2,
  parameter int WEIGHT_BITS = 3,
  parameter int TIME_PERIOD = `TIME_PERIOD,
  parameter int INIT_WEIGHT = 2 ** (WEIGHT_BITS - 1)
`ifdef STDP_STOCHASTIC_EN
  ,
  parameter int UPDATE_PROB = 8
`endif
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [$clog2(TIME_PERIOD)-1:0]                   cycle,
  input  logic [NEURONS-1:0][SYNAPSES-1:0]                 input_spikes,
  input  logic [NEURONS-1:0]                               output_spikes,
  input  logic                                             learn_en,
  output logic [NEURONS-1:0][SYNAPSES-1:0][WEIGHT_BITS-1:0] weights,
  output logic                                             busy,
  output logic                                             sweep_done
);
  localparam int TW    = $clog2(TIME_PERIOD);
  localparam int PAIRS = NEURONS * SYNAPSES;
  localparam int IW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [WEIGHT_BITS-1:0] WMAX  = '1;
  localparam logic [WEIGHT_BITS-1:0] WINIT = WEIGHT_BITS'(INIT_WEIGHT);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     idx;
  logic              snap_edge;
  logic [TW-1:0]     in_t       [PAIRS];
  logic [PAIRS-1:0]  in_v;
  logic [TW-1:0]     out_t      [NEURONS];
  logic [NEURONS-1:0] out_v;
  logic [TW-1:0]     snap_in_t  [PAIRS];
  logic [PAIRS-1:0]  snap_in_v;
  logic [TW-1:0]     snap_out_t [NEURONS];
  logic [NEURONS-1:0] snap_out_v;
  logic              p_in_v, p_out_v;
  logic [TW-1:0]     p_in_t, p_out_t;
  logic              upd_inc, upd_dec, upd_gate;

  assign snap_edge = (cycle == TW'(TIME_PERIOD - 1));

  // The last edge of a gamma cycle folds its own samples into the snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_v       <= '0;
      out_v      <= '0;
      snap_in_v  <= '0;
      snap_out_v <= '0;
      for (int k = 0; k < PAIRS; k++) begin
        in_t[k]      <= '0;
        snap_in_t[k] <= '0;
      end
      for (int n = 0; n < NEURONS; n++) begin
        out_t[n]      <= '0;
        snap_out_t[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NEURONS; n++) begin
        for (int s = 0; s < SYNAPSES; s++) begin
          if (snap_edge) begin
            snap_in_v[n*SYNAPSES+s] <= in_v[n*SYNAPSES+s] | ~input_spikes[n][s];
            snap_in_t[n*SYNAPSES+s] <= in_v[n*SYNAPSES+s] ? in_t[n*SYNAPSES+s] : cycle;
            in_v[n*SYNAPSES+s]      <= 1'b0;
            in_t[n*SYNAPSES+s]      <= '0;
          end else if (!input_spikes[n][s] && !in_v[n*SYNAPSES+s]) begin
            in_v[n*SYNAPSES+s] <= 1'b1;
            in_t[n*SYNAPSES+s] <= cycle;
          end
        end
        if (snap_edge) begin
          snap_out_v[n] <= out_v[n] | ~output_spikes[n];
          snap_out_t[n] <= out_v[n] ? out_t[n] : cycle;
          out_v[n]      <= 1'b0;
          out_t[n]      <= '0;
        end else if (!output_spikes[n] && !out_v[n]) begin
          out_v[n] <= 1'b1;
          out_t[n] <= cycle;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= (state == SWEEP && int'(idx) != PAIRS - 1) ? idx + 1'b1 : '0;
    end
  end

  // DONE also accepts a snapshot so a sweep filling TIME_PERIOD-1 clocks never drops one.
  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    sweep_done = 1'b0;
    case (state)
      IDLE:  if (snap_edge) state_nx = SWEEP;
      SWEEP: begin
        busy = 1'b1;
        if (int'(idx) == PAIRS - 1) state_nx = DONE;
      end
      DONE: begin
        sweep_done = 1'b1;
        state_nx   = snap_edge ? SWEEP : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    p_in_v  = 1'b0;
    p_in_t  = '0;
    p_out_v = 1'b0;
    p_out_t = '0;
    for (int k = 0; k < PAIRS; k++) begin
      if (int'(idx) == k) begin
        p_in_v = snap_in_v[k];
        p_in_t = snap_in_t[k];
      end
    end
    for (int n = 0; n < NEURONS; n++) begin
      if (int'(idx) / SYNAPSES == n) begin
        p_out_v = snap_out_v[n];
        p_out_t = snap_out_t[n];
      end
    end
    upd_inc = p_in_v && (!p_out_v || p_in_t <= p_out_t);
    upd_dec = p_out_v && (!p_in_v || p_in_t > p_out_t);
  end

`ifdef STDP_STOCHASTIC_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign upd_gate = ({1'b0, lfsr[3:0]} < 5'(UPDATE_PROB));
`else
  assign upd_gate = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NEURONS; n++)
        for (int s = 0; s < SYNAPSES; s++)
          weights[n][s] <= WINIT;
    end else if (state == SWEEP && learn_en && upd_gate) begin
      for (int n = 0; n < NEURONS; n++) begin
        for (int s = 0; s < SYNAPSES; s++) begin
          if (n * SYNAPSES + s == int'(idx)) begin
            if (upd_inc && weights[n][s] != WMAX)
              weights[n][s] <= weights[n][s] + WEIGHT_BITS'(1);
            else if (upd_dec && weights[n][s] != '0)
              weights[n][s] <= weights[n][s] - WEIGHT_BITS'(1);
          end
        end
      end
    end
  end

  snap_while_busy: assert property (@(posedge clk) disable iff (rst) !(snap_edge && busy));

endmodule
